// File: rtl/up_down_counter_gen.sv
// Up/down counter with clamped load, underflow reload register and a
// flag-event counter that wraps every FLAG_LIMIT passes through FLAG_VALUE.
module up_down_counter_gen #(
  parameter int WIDTH      = 8,
  parameter int MAX_COUNT  = 60,
  parameter int FLAG_VALUE = 30,
  parameter int FLAG_LIMIT = 100,
  parameter int FW         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             flag,
  output logic [FW-1:0]    flag_count,
  output logic             flag_wrap
);

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] FLAG_C  = WIDTH'(FLAG_VALUE);
  localparam logic [FW-1:0]    FC_LAST = FW'(FLAG_LIMIT - 1);

  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_next;
  logic             flag_event;

  assign zero = (count == '0);
  assign flag = (count == FLAG_C);
  assign tc   = en & ((mode & (count == MAX_C)) | (~mode & (count == '0)));

  // Clamping the load keeps count (and the reload value) within 0..MAX_COUNT.
  assign load_clamped = (load_val > MAX_C) ? MAX_C : load_val;

  // A flag pass only counts while actually counting, not on a load cycle.
  assign flag_event = flag & en & ~load;

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_clamped;
    end else if (en) begin
      if (mode) begin
        count_next = (count == MAX_C) ? '0 : count + WIDTH'(1);
      end else begin
        count_next = (count == '0) ? reload_q : count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      reload_q <= MAX_C;
    end else begin
      count <= count_next;
      if (load) begin
        reload_q <= load_clamped;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_count <= '0;
      flag_wrap  <= 1'b0;
    end else if (flag_clr) begin
      flag_count <= '0;
      flag_wrap  <= 1'b0;
    end else if (flag_event) begin
      if (flag_count == FC_LAST) begin
        flag_count <= '0;
        flag_wrap  <= 1'b1;
      end else begin
        flag_count <= flag_count + FW'(1);
        flag_wrap  <= 1'b0;
      end
    end else begin
      flag_wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_up_down_counter_gen.sv
// Bench for up_down_counter_gen: directed scenarios with literal expectations
// plus random stimulus, all checked every cycle against an integer model.
module tb_up_down_counter_gen;

  localparam int WIDTH      = 8;
  localparam int MAX_COUNT  = 60;
  localparam int FLAG_VALUE = 30;
  localparam int FLAG_LIMIT = 3;
  localparam int FW         = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             mode = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             flag_clr = 1'b0;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             tc;
  logic             flag;
  logic [FW-1:0]    flag_count;
  logic             flag_wrap;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  // model state, plain integers
  int m_cnt, m_rel, m_fc;
  bit m_wrap;

  up_down_counter_gen #(
    .WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT), .FLAG_VALUE(FLAG_VALUE),
    .FLAG_LIMIT(FLAG_LIMIT), .FW(FW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .flag_clr(flag_clr), .count(count), .zero(zero),
    .tc(tc), .flag(flag), .flag_count(flag_count), .flag_wrap(flag_wrap)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_rel = MAX_COUNT; m_fc = 0; m_wrap = 0;
    end else begin
      bit ev;
      int v;
      ev = (m_cnt == FLAG_VALUE) && en && !load;
      if (flag_clr) begin
        m_fc = 0; m_wrap = 0;
      end else if (ev) begin
        m_wrap = ((m_fc + 1) % FLAG_LIMIT) == 0;
        m_fc   = (m_fc + 1) % FLAG_LIMIT;
      end else begin
        m_wrap = 0;
      end
      if (load) begin
        v = (int'(load_val) > MAX_COUNT) ? MAX_COUNT : int'(load_val);
        m_cnt = v; m_rel = v;
      end else if (en) begin
        if (mode) m_cnt = (m_cnt + 1) % (MAX_COUNT + 1);
        else      m_cnt = (m_cnt == 0) ? m_rel : m_cnt - 1;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      chk("count", count, m_cnt);
      chk("zero", zero, m_cnt == 0);
      chk("flag", flag, m_cnt == FLAG_VALUE);
      chk("tc", tc, en && ((mode && m_cnt == MAX_COUNT) || (!mode && m_cnt == 0)));
      chk("flag_count", flag_count, m_fc);
      chk("flag_wrap", flag_wrap, m_wrap);
    end
  end

  // driver: apply inputs for one edge, return 1 time unit after it
  task automatic cyc(input bit e, input bit m, input bit ld, input int lv, input bit clr);
    en = e; mode = m; load = ld; load_val = lv[WIDTH-1:0]; flag_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pass_n;
    int exp_c;
    #12;
    @(posedge clk); #1;
    rst = 1'b0;
    cmp_on = 1'b1;

    // reset state
    chk("rst_count", count, 0);
    chk("rst_zero", zero, 1);
    chk("rst_flag", flag, FLAG_VALUE == 0);
    chk("rst_flag_count", flag_count, 0);
    chk("rst_flag_wrap", flag_wrap, 0);

    // up-wrap, three full passes for flag wrap
    pass_n = 0;
    for (int k = 1; k <= 3 * (MAX_COUNT + 1); k++) begin
      cyc(1, 1, 0, 0, 0);
      exp_c = k % (MAX_COUNT + 1);
      chk("up_count", count, exp_c);
      chk("up_tc", tc, exp_c == MAX_COUNT);
      if (exp_c == FLAG_VALUE + 1) begin
        pass_n++;
        chk("up_flag_count", flag_count, pass_n % 3);
        chk("up_flag_wrap", flag_wrap, (pass_n % 3) == 0);
      end
    end

    // down-reload from load 5
    cyc(0, 0, 1, 5, 0);
    chk("load5", count, 5);
    for (int k = 4; k >= -1; k--) begin
      cyc(1, 0, 0, 0, 0);
      exp_c = (k < 0) ? 5 : k;
      chk("down_count", count, exp_c);
      chk("down_tc", tc, exp_c == 0);
    end

    // load clamp and clamped reload
    cyc(0, 0, 1, 200, 0);
    chk("clamp", count, MAX_COUNT);
    for (int k = 0; k < MAX_COUNT; k++) cyc(1, 0, 0, 0, 0);
    chk("clamp_down_zero", count, 0);
    cyc(1, 0, 0, 0, 0);
    chk("clamp_reload", count, MAX_COUNT);

    // simultaneous flag event and clear, then load against en
    cyc(0, 1, 1, FLAG_VALUE, 0);
    chk("sim_flag", flag, 1);
    cyc(1, 1, 0, 0, 1);
    chk("sim_clr_fc", flag_count, 0);
    chk("sim_clr_wrap", flag_wrap, 0);
    chk("sim_clr_count", count, FLAG_VALUE + 1);
    cyc(1, 1, 1, 10, 0);
    chk("load_wins", count, 10);
    cyc(0, 1, 1, FLAG_VALUE, 0);
    cyc(1, 1, 1, 7, 0);
    chk("load_no_event", flag_count, 0);
    chk("load_no_event_cnt", count, 7);

    // async reset mid-count at 42 with nonzero flag_count
    cyc(0, 1, 1, FLAG_VALUE, 0);
    cyc(1, 1, 0, 0, 0);
    chk("pre_rst_fc", flag_count, 1);
    cyc(0, 1, 1, 42, 0);
    chk("pre_rst_count", count, 42);
    en = 1'b0; load = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_count", count, 0);
    chk("async_fc", flag_count, 0);
    chk("async_wrap", flag_wrap, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    cyc(1, 0, 0, 0, 0);
    chk("post_rst_reload", count, MAX_COUNT);
    cyc(1, 1, 0, 0, 0);
    chk("mode_switch", count, 0);

    // randomized stimulus
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 15) == 0, int'($urandom_range(0, 255)),
          $urandom_range(0, 19) == 0);
    end

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
